// File: rtl/conv_mac_tree.sv
// Pipelined K x K signed dot product: registered products, a registered binary adder tree,
// then bias add and truncation. Optional ReLU on the result via macro CONV_MAC_RELU_EN.
// Flat element [row][col] of window/weights occupies bits (row*K+col)*DATA_W +: DATA_W.
module conv_mac_tree #(
    parameter int K      = 5,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [K*K*DATA_W-1:0]   window,
    input  logic [K*K*DATA_W-1:0]   weights,
    input  logic [ACC_W-1:0]        bias,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        result
);

    localparam int unsigned N  = K * K;
    localparam int unsigned T  = $clog2(N);
    localparam int unsigned PW = 2 * DATA_W;
    localparam int unsigned IW = PW + T;

    function automatic int unsigned level_cnt(input int unsigned l);
        int unsigned c;
        c = N;
        for (int unsigned i = 0; i < l; i++) c = (c + 1) / 2;
        return c;
    endfunction

    logic                   stall;
    logic                   en;
    logic [T:0]             vld;
    logic [ACC_W-1:0]       bias_q [T+1];
    logic signed [ACC_W-1:0] trunc_sum;
    logic signed [ACC_W-1:0] final_val;

    assign stall    = out_valid & ~out_ready;
    assign en       = ~stall;
    assign in_ready = ~stall | rst;

    // Level 0 holds the sign-extended products; level l holds ceil(prev/2) partial sums.
    for (genvar l = 0; l <= T; l++) begin : lvl
        localparam int unsigned CNT = level_cnt(l);
        logic signed [IW-1:0] node [CNT];

        if (l == 0) begin : g_prod
            logic signed [PW-1:0] prod [N];

            always_ff @(posedge clk) begin
                if (en) begin
                    for (int unsigned i = 0; i < N; i++) begin
                        prod[i] <= PW'($signed(window[i*DATA_W +: DATA_W]))
                                 * PW'($signed(weights[i*DATA_W +: DATA_W]));
                    end
                end
            end

            always_comb begin
                for (int unsigned i = 0; i < N; i++) node[i] = IW'(prod[i]);
            end
        end else begin : g_add
            localparam int unsigned PREV = level_cnt(l - 1);

            always_ff @(posedge clk) begin
                if (en) begin
                    for (int unsigned j = 0; j < PREV / 2; j++) begin
                        node[j] <= lvl[l-1].node[2*j] + lvl[l-1].node[2*j+1];
                    end
                    if (PREV % 2 == 1) node[CNT-1] <= lvl[l-1].node[PREV-1];
                end
            end
        end
    end

    // Adding in ACC_W directly is equivalent to full-width add followed by wrap.
    assign trunc_sum = ACC_W'(lvl[T].node[0]) + $signed(bias_q[T]);

`ifdef CONV_MAC_RELU_EN
    assign final_val = trunc_sum[ACC_W-1] ? '0 : trunc_sum;
`else
    assign final_val = trunc_sum;
`endif

    always_ff @(posedge clk) begin
        if (en) begin
            bias_q[0] <= bias;
            for (int unsigned l = 1; l <= T; l++) bias_q[l] <= bias_q[l-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
        end else if (en) begin
            vld       <= {vld[T-1:0], in_valid};
            out_valid <= vld[T];
            if (vld[T]) result <= final_val;
        end
    end

endmodule

// File: tb/tb_conv_mac_tree.sv
// Directed bench for conv_mac_tree (K=5): table of uniform/ramp patterns plus
// backpressure, reset-in-flight and bubble sequences.
module tb_conv_mac_tree;

    localparam int K  = 5;
    localparam int DW = 8;
    localparam int AW = 32;
    localparam int NE = K * K;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [NE*DW-1:0]     window;
    logic [NE*DW-1:0]     weights;
    logic [AW-1:0]        bias;
    logic                 out_valid;
    logic                 out_ready;
    logic [AW-1:0]        result;

    int tests = 0;
    int fails = 0;

    conv_mac_tree #(.K(K), .DATA_W(DW), .ACC_W(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .window(window), .weights(weights), .bias(bias),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        int win;
        int wt;
        int ramp;
        int b;
        int exp;
    } vec_t;

    function automatic int relu(input int v);
`ifdef CONV_MAC_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [NE*DW-1:0] fill(input int v);
        logic [NE*DW-1:0] f;
        for (int i = 0; i < NE; i++) f[i*DW +: DW] = DW'(v);
        return f;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_one(input logic [NE*DW-1:0] w, input logic [NE*DW-1:0] g,
                           input int b, input int e, input string name);
        int n;
        window = w; weights = g; bias = b; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({name, " in_ready"}, int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, " latency"}, n, 7);
        check({name, " result"}, $signed(result), e);
        @(posedge clk); #1;
        check({name, " single"}, int'(out_valid), 0);
    endtask

    vec_t tbl [9];

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NE*DW-1:0] rw, rg;
        int sent, got, cyc, prev_stall, prev_res;
        int stale;

        tbl[0] = '{1, 1, 0, 0, 25};
        tbl[1] = '{-128, -128, 0, -1, 409599};
        tbl[2] = '{-128, 127, 0, 0, relu(-406400)};
        tbl[3] = '{2, -3, 0, 100, relu(-50)};
        tbl[4] = '{0, 0, 0, -7, relu(-7)};
        tbl[5] = '{127, 127, 0, 5, 403230};
        tbl[6] = '{0, 0, 0, 2147483647, 2147483647};
        tbl[7] = '{127, 127, 0, 2147483647, relu(-2147080424)};
        tbl[8] = '{0, 0, 1, 0, 1300};

        for (int i = 0; i < NE; i++) begin
            rw[i*DW +: DW] = DW'(i - 12);
            rg[i*DW +: DW] = DW'(i);
        end

        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        window = fill(3); weights = fill(3); bias = 0;
        repeat (3) begin
            @(posedge clk); #1;
            check("reset out_valid", int'(out_valid), 0);
            check("reset result", int'(result), 0);
            check("reset in_ready", int'(in_ready), 1);
        end
        rst = 1'b0; in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("reset discards input", int'(out_valid), 0);

        for (int t = 0; t < 9; t++) begin
            if (tbl[t].ramp != 0)
                run_one(rw, rg, tbl[t].b, tbl[t].exp, $sformatf("vec%0d", t));
            else
                run_one(fill(tbl[t].win), fill(tbl[t].wt), tbl[t].b, tbl[t].exp,
                        $sformatf("vec%0d", t));
        end

        // Back-to-back with out_ready cycling 1,0,0,1.
        sent = 0; got = 0; cyc = 0; prev_stall = 0; prev_res = 0;
        window = fill(1); weights = fill(1);
        while (got < 10 && cyc < 200) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            in_valid  = (sent < 10);
            bias      = sent;
            #1;
            check("bp in_ready", int'(in_ready), int'(!(out_valid && !out_ready)));
            if (prev_stall != 0) begin
                check("bp hold valid", int'(out_valid), 1);
                check("bp hold result", int'(result), prev_res);
            end
            if (out_valid && out_ready) begin
                check("bp order", $signed(result), 25 + got);
                got++;
            end
            prev_stall = int'(out_valid && !out_ready);
            prev_res   = int'(result);
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        check("bp count", got, 10);
        in_valid = 1'b0; out_ready = 1'b1;
        stale = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        check("bp no duplicate", stale, 0);

        // Reset with four transactions in flight.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; bias = 100 + i;
            @(posedge clk); #1;
        end
        rst = 1'b1; in_valid = 1'b1; bias = 200;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        check("midreset out_valid", int'(out_valid), 0);
        check("midreset result", int'(result), 0);
        stale = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        check("midreset no stale", stale, 0);
        run_one(fill(1), fill(1), 0, 25, "post reset");

        // Alternating bubbles propagate with the data.
        for (int c = 0; c < 20; c++) begin
            int ev;
            in_valid = (c < 8) && (c % 2 == 0);
            bias = c; out_ready = 1'b1;
            #1;
            ev = int'(c >= 7 && c < 15 && (c - 7) % 2 == 0);
            check($sformatf("bubble valid c%0d", c), int'(out_valid), ev);
            if (ev != 0) check($sformatf("bubble result c%0d", c), $signed(result), 25 + c - 7);
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/conv_mac_tree.md
CONV_MAC_TREE -- requirements
Module: conv_mac_tree

Interface
REQ-001 Parameter K, default 5: kernel edge; window and weights are K x K.
REQ-002 Parameter DATA_W, default 8: signed width of each window and weight element.
REQ-003 Parameter ACC_W, default 32: signed width of bias and result.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 in_valid  input  1  window/weights/bias valid this cycle.
REQ-007 in_ready  output  1  block accepts input this cycle.
REQ-008 window  input  K x K x DATA_W signed  activation patch, indexed [row][col].
REQ-009 weights  input  K x K x DATA_W signed  kernel, indexed [row][col].
REQ-010 bias  input  ACC_W signed  added once to the dot product.
REQ-011 out_valid  output  1  result holds a completed sum.
REQ-012 out_ready  input  1  downstream accepts result this cycle.
REQ-013 result  output  ACC_W signed  sum over i,j of window[i][j]*weights[i][j], plus bias.

Function
REQ-014 The block SHALL accept an input transfer on any cycle where in_valid and in_ready are both 1.
REQ-015 The block SHALL output a transfer on any cycle where out_valid and out_ready are both 1.
REQ-016 Stage 0 SHALL register all K*K signed products at full 2*DATA_W width.
REQ-017 Stages 1..T SHALL form a registered binary adder tree, T = clog2(K*K), with one tree level per stage.
REQ-018 An odd leftover operand at any tree level SHALL pass through that stage unchanged.
REQ-019 Tree operands SHALL be sign-extended to the full intermediate width, so no stage overflows.
REQ-020 Bias SHALL travel with its transaction and be added in the final stage.
REQ-021 In the final stage the sum SHALL be truncated to ACC_W bits, two's-complement wrap, and registered into result.
REQ-022 Latency from input transfer to out_valid SHALL be exactly T+2 cycles when there is no stall; for K=5 this is 7 cycles.
REQ-023 Throughput SHALL be one transaction per cycle when there is no stall.
REQ-024 Each stage SHALL carry a valid bit; bubbles (in_valid=0) SHALL propagate as invalid stages.
REQ-025 The pipeline SHALL stall when out_valid=1 and out_ready=0.
REQ-026 On a stall, every stage register and result SHALL hold its value.
REQ-027 in_ready SHALL equal NOT stall; it is combinational from out_valid and out_ready only.
REQ-028 in_ready SHALL NOT depend on in_valid.
REQ-029 When out_valid=0, the pipeline SHALL advance regardless of out_ready.
REQ-030 Transactions SHALL leave in acceptance order, with none dropped or duplicated under any out_ready pattern.

Reset
REQ-031 While rst=1 on a clock edge, all stage valid bits SHALL clear, out_valid SHALL be 0 and result SHALL be 0.
REQ-032 While rst=1, in_ready SHALL be 1.
REQ-033 Inputs presented during a reset cycle SHALL be discarded.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight transactions, with no later out_valid for them.
REQ-035 Product and tree data registers need no reset; only valid bits and result are reset.

Configuration
REQ-036 With macro CONV_MAC_RELU_EN defined, the final stage SHALL output max(truncated sum, 0): negative results become 0.
REQ-037 With CONV_MAC_RELU_EN undefined, the signed truncated sum SHALL pass unmodified.
REQ-038 Latency and handshake SHALL be identical in both builds.

Verification
REQ-039 K=5, all window=1, all weights=1, bias=0, out_ready=1 -> result=25 with out_valid high exactly 7 cycles after acceptance.
REQ-040 All window=-128, all weights=-128, bias=-1 -> result=409599; all window=-128, all weights=127, bias=0 -> result=-406400 (without ReLU), 0 (with CONV_MAC_RELU_EN).
REQ-041 10 back-to-back transactions with bias=0..9, out_ready toggling 1,0,0,1 repeatedly -> 10 results in order, values held stable during stalls, in_ready low exactly on stall cycles.
REQ-042 rst pulsed 1 cycle while 4 transactions are in flight -> out_valid=0 and result=0 next cycle; no stale results afterwards; a new transaction completes in 7 cycles.
REQ-043 Alternating in_valid 1,0 with out_ready=1 -> out_valid alternates 1,0 after latency, matching the input bubble pattern.
REQ-044 K=3, DATA_W=4, ACC_W=12 rebuild; window=7, weights=-8, bias=0 -> result=-504, latency 6 cycles.
